// File: rtl/mips_memory_bus_pkg.sv
// Memory map shared by the MIPS core, the memory bus and the benches:
// region bases, MMIO register addresses and the unmapped-read pattern.
package mips_memory_bus_pkg;

  localparam logic [31:0] TEXT_BASE      = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE      = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE      = 32'hFFFF_0000;

  localparam logic [31:0] LED_OFFSET     = 32'h0000_0000;
  localparam logic [31:0] CYCLES_OFFSET  = 32'h0000_0004;
  localparam logic [31:0] CONSOLE_OFFSET = 32'h0000_0008;
  localparam logic [31:0] ERRSTAT_OFFSET = 32'h0000_000C;

  localparam logic [31:0] LED_ADDR       = MMIO_BASE + LED_OFFSET;
  localparam logic [31:0] CYCLES_ADDR    = MMIO_BASE + CYCLES_OFFSET;
  localparam logic [31:0] CONSOLE_ADDR   = MMIO_BASE + CONSOLE_OFFSET;
  localparam logic [31:0] ERRSTAT_ADDR   = MMIO_BASE + ERRSTAT_OFFSET;

  localparam logic [31:0] UNMAPPED_VALUE = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    REGION_TEXT,
    REGION_DATA,
    REGION_LED,
    REGION_CYCLES,
    REGION_CONSOLE,
    REGION_ERRSTAT,
    REGION_UNMAPPED
  } region_e;

  // Byte offsets within a word are ignored; all accesses are whole words.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned text_words,
                                            input int unsigned data_words);
    logic [31:0] word_addr;
    word_addr = addr & ~32'h3;
    if ((word_addr - TEXT_BASE) < (text_words << 2)) return REGION_TEXT;
    if ((word_addr - DATA_BASE) < (data_words << 2)) return REGION_DATA;
    case (word_addr)
      LED_ADDR:     return REGION_LED;
      CYCLES_ADDR:  return REGION_CYCLES;
      CONSOLE_ADDR: return REGION_CONSOLE;
      ERRSTAT_ADDR: return REGION_ERRSTAT;
      default:      return REGION_UNMAPPED;
    endcase
  endfunction

endpackage

// File: rtl/mips_memory_bus_console_fifo.sv
// console_fifo: byte FIFO with push/pop, full/empty/count and an overflow
// strobe for a push that could not be accepted this cycle.
module console_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    storage [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;
  assign data     = empty ? 8'h00 : storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) storage[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mips_memory_bus.sv
// mips_memory_bus: decodes the multicycle core's single memory port into
// text RAM, data RAM and an MMIO page. Optional macro: MIPS_MEM_INIT_EN.
module mips_memory_bus
  import mips_memory_bus_pkg::*;
#(
  parameter int unsigned TEXT_WORDS    = 1024,
  parameter int unsigned DATA_WORDS    = 1024,
  parameter int unsigned CONSOLE_DEPTH = 4
`ifdef MIPS_MEM_INIT_EN
  ,
  parameter TEXT_INIT_FILE = "text.hex",
  parameter DATA_INIT_FILE = "data.hex"
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic [7:0]  leds,
  output logic        bus_error
);

  localparam int TW = $clog2(TEXT_WORDS);
  localparam int DW = $clog2(DATA_WORDS);
  localparam int FW = $clog2(CONSOLE_DEPTH) + 1;

  logic [31:0] text_ram [TEXT_WORDS];
  logic [31:0] data_ram [DATA_WORDS];

  region_e       region;
  logic          wr;
  logic [TW-1:0] text_idx;
  logic [DW-1:0] data_idx;
  logic [31:0]   read_value;
  logic [31:0]   cycles;
  logic [1:0]    errstat;

  logic          fifo_push;
  logic [FW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_overflow;

  assign region = decode_region(mem_addr, TEXT_WORDS, DATA_WORDS);
  assign wr     = mem_wr_ena && !rst;
  // Region bases are aligned to their sizes, so the low word bits index directly.
  assign text_idx = mem_addr[TW+1:2];
  assign data_idx = mem_addr[DW+1:2];

  assign fifo_push     = wr && (region == REGION_CONSOLE);
  assign console_valid = !fifo_empty;
  assign bus_error     = |errstat;

  console_fifo #(
    .DEPTH (CONSOLE_DEPTH)
  ) u_console_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mem_wr_data[7:0]),
    .pop       (console_ready),
    .data      (console_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow)
  );

  always_ff @(posedge clk) begin
    if (wr && (region == REGION_TEXT)) text_ram[text_idx] <= mem_wr_data;
    if (wr && (region == REGION_DATA)) data_ram[data_idx] <= mem_wr_data;
  end

  // All sources are sampled before the edge, which gives read-first behaviour.
  always_comb begin
    read_value = UNMAPPED_VALUE;
    case (region)
      REGION_TEXT:    read_value = text_ram[text_idx];
      REGION_DATA:    read_value = data_ram[data_idx];
      REGION_LED:     read_value = {24'h0, leds};
      REGION_CYCLES:  read_value = cycles;
      REGION_CONSOLE: read_value = {16'h0, 8'(fifo_count), 6'h0, fifo_full, fifo_empty};
      REGION_ERRSTAT: read_value = {30'h0, errstat};
      default:        read_value = UNMAPPED_VALUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_data <= 32'h0;
      leds        <= 8'h0;
      cycles      <= 32'h0;
      errstat     <= 2'b00;
    end else begin
      mem_rd_data <= read_value;
      if (wr && (region == REGION_LED)) leds <= mem_wr_data[7:0];
      if (wr && (region == REGION_CYCLES)) cycles <= 32'h0;
      else                                 cycles <= cycles + 32'd1;
      // Clearing wins over any error raised in the same cycle.
      if (wr && (region == REGION_ERRSTAT)) errstat <= 2'b00;
      else errstat <= errstat | {fifo_overflow, region == REGION_UNMAPPED};
    end
  end

endmodule

// File: tb/tb_mips_memory_bus.sv
// Self-checking bench for mips_memory_bus: a transaction-level model of the
// memory map checked every cycle, plus directed literal checks.
module tb_mips_memory_bus;

  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0004;
  localparam logic [31:0] A_CON  = 32'hFFFF_0008;
  localparam logic [31:0] A_ERR  = 32'hFFFF_000C;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready;
  logic [7:0]  leds;
  logic        bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  mips_memory_bus dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ena    (mem_wr_ena),
    .mem_rd_data   (mem_rd_data),
    .console_data  (console_data),
    .console_valid (console_valid),
    .console_ready (console_ready),
    .leds          (leds),
    .bus_error     (bus_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: what the memory map must hold after each edge.
  logic [31:0] ram_m [logic [31:0]];
  logic [7:0]  q [$];
  logic [31:0] m_rd;
  bit          m_rd_known;
  logic [7:0]  m_leds;
  logic [31:0] m_cycles;
  logic [1:0]  m_err;
  bit          m_valid = 0;

  always @(posedge clk) begin : model
    logic [31:0] w;
    logic [31:0] rv;
    int          sz;
    bit          known, unm, popped, ovf, is_ram;
    w = mem_addr & ~32'h3;
    if (rst) begin
      m_rd = 32'h0;
      m_rd_known = 1;
      q.delete();
      m_leds = 8'h0;
      m_cycles = 32'h0;
      m_err = 2'b00;
      m_valid = 1;
    end else begin
      sz = q.size();
      known = 1;
      unm = 0;
      ovf = 0;
      is_ram = (w >= 32'h0040_0000 && w <= 32'h0040_0FFC) ||
               (w >= 32'h1001_0000 && w <= 32'h1001_0FFC);
      rv = 32'hDEAD_BEEF;
      if (is_ram) begin
        if (ram_m.exists(w)) rv = ram_m[w];
        else known = 0;
      end else if (w == A_LED) rv = {24'h0, m_leds};
      else if (w == A_CYC) rv = m_cycles;
      else if (w == A_CON) rv = {16'h0, 8'(sz), 6'h0, sz == 4, sz == 0};
      else if (w == A_ERR) rv = {30'h0, m_err};
      else unm = 1;
      popped = (sz > 0) && console_ready;
      if (popped) void'(q.pop_front());
      if (mem_wr_ena) begin
        if (is_ram) ram_m[w] = mem_wr_data;
        else if (w == A_LED) m_leds = mem_wr_data[7:0];
        else if (w == A_CON) begin
          if (sz < 4 || popped) q.push_back(mem_wr_data[7:0]);
          else ovf = 1;
        end
      end
      m_cycles = (mem_wr_ena && w == A_CYC) ? 32'h0 : m_cycles + 32'd1;
      if (mem_wr_ena && w == A_ERR) m_err = 2'b00;
      else begin
        if (unm) m_err[0] = 1'b1;
        if (ovf) m_err[1] = 1'b1;
      end
      m_rd = rv;
      m_rd_known = known;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      if (m_rd_known) checkOutput("model rd_data", mem_rd_data, m_rd);
      checkOutput("model leds", {24'h0, leds}, {24'h0, m_leds});
      checkOutput("model bus_error", {31'h0, bus_error}, {31'h0, |m_err});
      checkOutput("model console_valid", {31'h0, console_valid}, {31'h0, q.size() > 0});
      checkOutput("model console_data", {24'h0, console_data},
                  (q.size() > 0) ? {24'h0, q[0]} : 32'h0);
    end
  end

  task automatic applyStimulus(input logic r, input logic [31:0] a,
                               input logic [31:0] d, input logic we,
                               input logic rdy);
    rst = r;
    mem_addr = a;
    mem_wr_data = d;
    mem_wr_ena = we;
    console_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] drain_exp [4] = '{8'h42, 8'h43, 8'h44, 8'h46};

  initial begin
    rst = 1'b1;
    mem_addr = A_LED;
    mem_wr_data = 32'h0;
    mem_wr_ena = 1'b0;
    console_ready = 1'b0;

    repeat (3) applyStimulus(1, A_LED, 32'h0, 0, 0);
    checkOutput("reset rd_data", mem_rd_data, 32'h0);
    checkOutput("reset leds", {24'h0, leds}, 32'h0);
    checkOutput("reset console_valid", {31'h0, console_valid}, 32'h0);
    checkOutput("reset console_data", {24'h0, console_data}, 32'h0);
    checkOutput("reset bus_error", {31'h0, bus_error}, 32'h0);

    repeat (10) applyStimulus(0, A_LED, 32'h0, 0, 0);
    applyStimulus(0, A_CYC, 32'h0, 0, 0);
    checkOutput("cycles after 10", mem_rd_data, 32'd10);
    applyStimulus(0, A_CYC, 32'h0, 1, 0);
    checkOutput("cycles on write", mem_rd_data, 32'd11);
    applyStimulus(0, A_CYC, 32'h0, 0, 0);
    checkOutput("cycles cleared", mem_rd_data, 32'd0);

    applyStimulus(0, 32'h1001_0004, 32'h1234_5678, 1, 0);
    applyStimulus(0, 32'h1001_0004, 32'h0, 0, 0);
    checkOutput("data read", mem_rd_data, 32'h1234_5678);
    applyStimulus(0, 32'h1001_0004, 32'hCAFE_F00D, 1, 0);
    checkOutput("read-first", mem_rd_data, 32'h1234_5678);
    applyStimulus(0, 32'h1001_0007, 32'h0, 0, 0);
    checkOutput("byte bits ignored", mem_rd_data, 32'hCAFE_F00D);
    applyStimulus(0, 32'h0040_0000, 32'h2402_000A, 1, 0);
    applyStimulus(0, 32'h0040_0FFC, 32'h1111_1111, 1, 0);
    applyStimulus(0, 32'h0040_0000, 32'h0, 0, 0);
    checkOutput("text first word", mem_rd_data, 32'h2402_000A);
    applyStimulus(0, 32'h0040_0FFC, 32'h0, 0, 0);
    checkOutput("text last word", mem_rd_data, 32'h1111_1111);
    applyStimulus(0, 32'h0040_1000, 32'h0, 0, 0);
    checkOutput("past text end", mem_rd_data, 32'hDEAD_BEEF);
    applyStimulus(0, A_ERR, 32'h0, 1, 0);

    for (int b = 8'h41; b <= 8'h45; b++) applyStimulus(0, A_CON, 32'(b), 1, 0);
    applyStimulus(0, A_CON, 32'h0, 0, 0);
    checkOutput("console status full", mem_rd_data, 32'h0000_0402);
    checkOutput("console head", {24'h0, console_data}, 32'h41);
    checkOutput("overflow error", {31'h0, bus_error}, 32'h1);
    applyStimulus(0, A_ERR, 32'h0, 1, 0);
    applyStimulus(0, A_CON, 32'h46, 1, 1);
    applyStimulus(0, A_ERR, 32'h0, 0, 0);
    checkOutput("push+pop no overflow", mem_rd_data, 32'h0);
    applyStimulus(0, A_CON, 32'h0, 0, 0);
    checkOutput("count stays 4", mem_rd_data, 32'h0000_0402);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain byte", {24'h0, console_data}, {24'h0, drain_exp[i]});
      applyStimulus(0, A_LED, 32'h0, 0, 1);
    end
    checkOutput("drained", {31'h0, console_valid}, 32'h0);

    applyStimulus(0, 32'h2000_0000, 32'h0, 0, 0);
    checkOutput("unmapped read", mem_rd_data, 32'hDEAD_BEEF);
    applyStimulus(0, A_ERR, 32'h0, 0, 0);
    checkOutput("errstat unmapped", mem_rd_data, 32'h1);
    applyStimulus(0, A_ERR, 32'h0, 1, 0);
    checkOutput("bus_error cleared", {31'h0, bus_error}, 32'h0);
    applyStimulus(0, A_ERR, 32'h0, 0, 0);
    checkOutput("errstat cleared", mem_rd_data, 32'h0);

    applyStimulus(0, A_LED, 32'hA5, 1, 0);
    checkOutput("leds written", {24'h0, leds}, 32'hA5);
    applyStimulus(0, A_LED, 32'h0, 0, 0);
    checkOutput("leds read", mem_rd_data, 32'hA5);
    applyStimulus(0, A_CON, 32'h61, 1, 0);
    applyStimulus(0, A_CON, 32'h62, 1, 0);
    checkOutput("queued before reset", {31'h0, console_valid}, 32'h1);
    applyStimulus(1, A_LED, 32'hFF, 1, 0);
    checkOutput("leds after reset", {24'h0, leds}, 32'h0);
    checkOutput("fifo after reset", {31'h0, console_valid}, 32'h0);
    checkOutput("rd after reset", mem_rd_data, 32'h0);
    applyStimulus(0, A_LED, 32'h0, 0, 0);
    checkOutput("write ignored in reset", mem_rd_data, 32'h0);
    applyStimulus(0, A_LED, 32'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
